clock_control_logic_frac_div: RTL and testbench

//  Clock-tree control node for a fractional divider (MFI + MFN/MFD).

---
 rtl/clock_logic_pkg.sv | 26 ++
 rtl/clock_logic_cross_sync_n.sv | 20 ++
 rtl/clock_control_logic_frac_div.sv | 164 ++++++++++++++++
 tb/tb_clock_control_logic_frac_div.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_logic_pkg.sv
// Shared types and helpers for the fractional-divider clock control node.
package clock_logic_pkg;

   typedef enum logic [2:0] {
      ST_STOPPED    = 3'd0,
      ST_STARTING   = 3'd1,
      ST_RUNNING    = 3'd2,
      ST_STOPPING   = 3'd3,
      ST_UPDATE_REQ = 3'd4,
      ST_UPDATE_REL = 3'd5
   } state_t;

   typedef struct packed {
      state_t state;
      logic   parent_starting;
      logic   en_s;
      logic   up_s;
   } dbg_t;

   // A ratio is usable only with a non-zero integer part and a proper fraction.
   function automatic logic cfg_ok(input logic [31:0] mfi, input logic [31:0] mfn,
                                   input logic [31:0] mfd);
      return (mfd != 0) && (mfn < mfd) && (mfi != 0);
   endfunction

endpackage

// File: rtl/clock_logic_cross_sync_n.sv
// Multi-flop synchroniser for a single slow level signal from the divider domain.
module clock_logic_cross_sync_n #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clock) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[STAGES-2:0], d};
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clock_control_logic_frac_div.sv
// Clock-tree node for a fractional divider: request fan-in, enable handshake and
// safe stop/update/restart reprogramming of the MFI/MFN/MFD ratios.
module clock_control_logic_frac_div
   import clock_logic_pkg::*;
#(
   parameter int NUM_CHILD     = 2,
   parameter int DIV_W         = 8,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 1,
   parameter int ACK_TIMEOUT   = 1023,
   parameter logic [DIV_W-1:0] RST_MFI = DIV_W'(2),
   parameter logic [DIV_W-1:0] RST_MFN = DIV_W'(3),
   parameter logic [DIV_W-1:0] RST_MFD = DIV_W'(5)
) (
   input  logic                 clock,
   input  logic                 reset,
   output logic                 parent_request,
   input  logic                 parent_ready,
   input  logic                 parent_silent,
   input  logic                 parent_starting,
   input  logic                 parent_stopping,
   input  logic [NUM_CHILD-1:0] child_request,
   output logic [NUM_CHILD-1:0] child_ready,
   output logic                 child_silent,
   output logic                 child_starting,
   output logic                 child_stopping,
   input  logic                 cfg_valid,
   input  logic [DIV_W-1:0]     cfg_mfi,
   input  logic [DIV_W-1:0]     cfg_mfn,
   input  logic [DIV_W-1:0]     cfg_mfd,
   output logic                 cfg_ready,
   output logic                 cfg_error,
   output logic                 async_enable,
   input  logic                 async_enable_ack,
   output logic                 async_update,
   output logic [DIV_W-1:0]     mfi,
   output logic [DIV_W-1:0]     mfn,
   output logic [DIV_W-1:0]     mfd,
   input  logic                 async_update_ack,
   output logic                 ack_fault,
   output dbg_t                 dbg
);

   localparam int FW = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
   localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

   // Handshake: cfg_valid and cfg_* are held by the requester until the single
   // cycle cfg_ready pulse; cfg_error qualifies that pulse. While cfg_ready is
   // high the still-asserted cfg_valid belongs to the finished request.
   state_t          state, next_state;
   logic            en_s, up_s;
   logic            any_req, go, cfg_act, cfg_good, accepting, reject, waiting;
   logic            en_req, en_req_d;
   logic [FW-1:0]   filter_cnt;
   logic [CW-1:0]   to_cnt;

   clock_logic_cross_sync_n #(.STAGES(SYNC_STAGES)) u_en_sync (
      .clock (clock),
      .reset (reset),
      .d     (async_enable_ack),
      .q     (en_s)
   );

   clock_logic_cross_sync_n #(.STAGES(SYNC_STAGES)) u_up_sync (
      .clock (clock),
      .reset (reset),
      .d     (async_update_ack),
      .q     (up_s)
   );

   assign any_req   = |child_request;
   assign go        = parent_ready & ~parent_stopping;
   assign cfg_act   = cfg_valid & ~cfg_ready;
   assign cfg_good  = cfg_ok(32'(cfg_mfi), 32'(cfg_mfn), 32'(cfg_mfd));
   assign accepting = (state == ST_STOPPED) || (state == ST_RUNNING);
   assign reject    = cfg_act & accepting & ~cfg_good;
   assign waiting   = (state == ST_STARTING) || (state == ST_STOPPING) ||
                      (state == ST_UPDATE_REQ) || (state == ST_UPDATE_REL);

   always_ff @(posedge clock) begin
      if (reset) state <= ST_STOPPED;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_STOPPED: begin
            if (cfg_act) begin
               if (cfg_good) next_state = ST_UPDATE_REQ;
            end else if (any_req && go) begin
               next_state = ST_STARTING;
            end
         end
         ST_STARTING: begin
            if (parent_stopping) next_state = ST_STOPPING;
            else if (en_s)       next_state = ST_RUNNING;
         end
         ST_RUNNING: begin
            if (!any_req || parent_stopping || (cfg_act && cfg_good)) next_state = ST_STOPPING;
         end
         ST_STOPPING: begin
            if (!async_enable && !en_s) next_state = ST_STOPPED;
         end
         ST_UPDATE_REQ: begin
            if (up_s) next_state = ST_UPDATE_REL;
         end
         ST_UPDATE_REL: begin
            if (!up_s) next_state = ST_STOPPED;
         end
         default: next_state = ST_STOPPED;
      endcase
   end

   always_comb begin
      parent_request = any_req || (state == ST_STARTING) || (state == ST_RUNNING) ||
                       (state == ST_STOPPING);
      child_ready    = (state == ST_RUNNING && parent_ready) ? child_request : '0;
      child_silent   = parent_silent || (state != ST_RUNNING);
      child_starting = (state == ST_STARTING);
      child_stopping = (state == ST_STOPPING);
      en_req_d       = (next_state == ST_STARTING) || (next_state == ST_RUNNING);
      dbg            = '{state: state, parent_starting: parent_starting, en_s: en_s, up_s: up_s};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         en_req       <= 1'b0;
         filter_cnt   <= '0;
         async_enable <= 1'b0;
         async_update <= 1'b0;
         to_cnt       <= '0;
         ack_fault    <= 1'b0;
         cfg_ready    <= 1'b0;
         cfg_error    <= 1'b0;
         mfi          <= RST_MFI;
         mfn          <= RST_MFN;
         mfd          <= RST_MFD;
      end else begin
         en_req <= en_req_d;
         if (en_req && !en_req_d)  filter_cnt <= FW'(FILTER_CYCLES);
         else if (filter_cnt != '0) filter_cnt <= filter_cnt - 1'b1;

         // Once the enable has dropped during STOPPING it must stay low.
         async_enable <= (en_req || (filter_cnt != '0)) &&
                         !(state == ST_STOPPING && !async_enable);
         async_update <= (state == ST_UPDATE_REQ) && (next_state == ST_UPDATE_REQ);

         if (!waiting || next_state != state) to_cnt <= '0;
         else if (to_cnt != CW'(ACK_TIMEOUT))  to_cnt <= to_cnt + 1'b1;
         if (ACK_TIMEOUT != 0 && waiting && to_cnt == CW'(ACK_TIMEOUT)) ack_fault <= 1'b1;

         cfg_ready <= reject || (state == ST_UPDATE_REL && next_state == ST_STOPPED);
         cfg_error <= reject;

         if (state == ST_STOPPED && next_state == ST_UPDATE_REQ) begin
            mfi <= cfg_mfi;
            mfn <= cfg_mfn;
            mfd <= cfg_mfd;
         end
      end
   end

endmodule

// File: tb/tb_clock_control_logic_frac_div.sv
// Randomised self-checking bench for clock_control_logic_frac_div.
module tb_clock_control_logic_frac_div;
   import clock_logic_pkg::*;

   localparam int NUM_CHILD     = 2;
   localparam int DIV_W         = 8;
   localparam int SYNC_STAGES   = 2;
   localparam int FILTER_CYCLES = 1;
   localparam int ACK_TIMEOUT   = 15;

   logic clock = 1'b0;
   logic reset;
   logic parent_request, parent_ready, parent_silent, parent_starting, parent_stopping;
   logic [NUM_CHILD-1:0] child_request, child_ready;
   logic child_silent, child_starting, child_stopping;
   logic cfg_valid, cfg_ready, cfg_error;
   logic [DIV_W-1:0] cfg_mfi, cfg_mfn, cfg_mfd, mfi, mfn, mfd;
   logic async_enable, async_enable_ack, async_update, async_update_ack, ack_fault;
   dbg_t dbg;

   int n_checks, n_fail;
   int en_dly, up_dly;
   bit en_auto, up_auto, model_running;
   logic [DIV_W-1:0] model_mfi, model_mfn, model_mfd;
   logic [0:0] exp_q[$];
   logic [15:0] en_hist, up_hist;
   int k, cr_seen;

   clock_control_logic_frac_div #(
      .NUM_CHILD(NUM_CHILD), .DIV_W(DIV_W), .SYNC_STAGES(SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clock(clock), .reset(reset),
      .parent_request(parent_request), .parent_ready(parent_ready),
      .parent_silent(parent_silent), .parent_starting(parent_starting),
      .parent_stopping(parent_stopping),
      .child_request(child_request), .child_ready(child_ready),
      .child_silent(child_silent), .child_starting(child_starting),
      .child_stopping(child_stopping),
      .cfg_valid(cfg_valid), .cfg_mfi(cfg_mfi), .cfg_mfn(cfg_mfn), .cfg_mfd(cfg_mfd),
      .cfg_ready(cfg_ready), .cfg_error(cfg_error),
      .async_enable(async_enable), .async_enable_ack(async_enable_ack),
      .async_update(async_update), .mfi(mfi), .mfn(mfn), .mfd(mfd),
      .async_update_ack(async_update_ack), .ack_fault(ack_fault), .dbg(dbg)
   );

   // clock / reset
   initial forever #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   // Divider-side model: acks echo the strobes after a programmable delay.
   initial begin
      en_hist = '0;
      up_hist = '0;
      async_enable_ack = 1'b0;
      async_update_ack = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         en_hist = {en_hist[14:0], async_enable};
         up_hist = {up_hist[14:0], async_update};
         async_enable_ack = en_auto ? en_hist[en_dly-1] : 1'b0;
         async_update_ack = up_auto ? up_hist[up_dly-1] : 1'b0;
      end
   end

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      child_request = '0;
      parent_ready = 1'b0;
      parent_silent = 1'b0;
      parent_starting = 1'b0;
      parent_stopping = 1'b0;
      cfg_valid = 1'b0;
      cfg_mfi = '0;
      cfg_mfn = '0;
      cfg_mfd = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      model_mfi = 8'd2;
      model_mfn = 8'd3;
      model_mfd = 8'd5;
      model_running = 1'b0;
   endtask

   task automatic start_clock(input logic [NUM_CHILD-1:0] req);
      int n;
      child_request = req;
      parent_ready = 1'b1;
      n = 0;
      while (child_ready != req && n < 40) begin
         tick();
         n++;
      end
      check_eq("start_child_ready", 32'(child_ready), 32'(req));
      check_eq("start_child_silent", 32'(child_silent), 32'(0));
      model_running = 1'b1;
   endtask

   task automatic stop_clock();
      int n;
      child_request = '0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(dbg.state == ST_STOPPED && !async_enable) && n < 40);
      check_eq("stop_child_silent", 32'(child_silent), 32'(1));
      check_eq("stop_parent_request", 32'(parent_request), 32'(0));
      model_running = 1'b0;
      repeat (16) tick();
   endtask

   task automatic run_cfg(input logic [DIV_W-1:0] ci, input logic [DIV_W-1:0] cn,
                          input logic [DIV_W-1:0] cd);
      logic exp_err, got_err;
      logic [0:0] exp_e;
      int n, pulses;
      bit seen_up, moved_en, saw_stop, en_low;
      logic [23:0] old_r, up_r;
      exp_err = (cd == 0) || (cn >= cd) || (ci == 0);
      exp_q.push_back(exp_err);
      old_r = {model_mfi, model_mfn, model_mfd};
      cfg_mfi = ci;
      cfg_mfn = cn;
      cfg_mfd = cd;
      cfg_valid = 1'b1;
      pulses = 0; seen_up = 0; moved_en = 0; saw_stop = 0; en_low = 0;
      up_r = '0; got_err = 1'b0; n = 0;
      while (pulses == 0 && n < 100) begin
         tick();
         n++;
         if (async_enable && {mfi, mfn, mfd} != old_r) moved_en = 1;
         if (child_stopping) saw_stop = 1;
         if (!async_enable) en_low = 1;
         if (async_update && !seen_up) begin
            seen_up = 1;
            up_r = {mfi, mfn, mfd};
         end
         if (cfg_ready) begin
            pulses = 1;
            got_err = cfg_error;
            cfg_valid = 1'b0;
         end
      end
      cfg_valid = 1'b0;
      exp_e = exp_q.pop_front();
      check_eq("cfg_ready_seen", 32'(pulses), 32'(1));
      check_eq("cfg_error", 32'(got_err), 32'(exp_e));
      if (exp_err) begin
         check_eq("rej_latency", 32'(n), 32'(1));
         check_eq("rej_no_update", 32'(seen_up), 32'(0));
         if (model_running) check_eq("rej_enable_held", 32'(en_low), 32'(0));
      end else begin
         model_mfi = ci;
         model_mfn = cn;
         model_mfd = cd;
         check_eq("upd_ratio_at_strobe", 32'(up_r), 32'({ci, cn, cd}));
         check_eq("upd_no_move_while_en", 32'(moved_en), 32'(0));
         if (model_running) check_eq("upd_via_stopping", 32'(saw_stop), 32'(1));
      end
      check_eq("ratios", 32'({mfi, mfn, mfd}), 32'({model_mfi, model_mfn, model_mfd}));
      tick();
      check_eq("cfg_ready_one_pulse", 32'(cfg_ready), 32'(0));
      if (!exp_err && model_running) begin
         n = 0;
         while (child_ready != child_request && n < 40) begin
            tick();
            n++;
         end
         check_eq("restart_child_ready", 32'(child_ready), 32'(child_request));
      end
   endtask

   initial begin
      int ci, cn, cd, mode;
      n_checks = 0;
      n_fail = 0;
      en_auto = 1'b1;
      up_auto = 1'b1;
      en_dly = 3;
      up_dly = 2;
      do_reset();

      check_eq("rst_child_silent", 32'(child_silent), 32'(1));
      check_eq("rst_ratios", 32'({mfi, mfn, mfd}), 32'({8'd2, 8'd3, 8'd5}));
      check_eq("rst_parent_request", 32'(parent_request), 32'(0));
      check_eq("rst_child_ready", 32'(child_ready), 32'(0));
      check_eq("rst_start_stop", 32'({child_starting, child_stopping}), 32'(0));
      check_eq("rst_cfg", 32'({cfg_ready, cfg_error}), 32'(0));
      check_eq("rst_async", 32'({async_enable, async_update}), 32'(0));
      check_eq("rst_ack_fault", 32'(ack_fault), 32'(0));

      // Directed start: enable two edges after request, RUNNING after ack sync.
      child_request = 2'b01;
      parent_ready = 1'b1;
      tick();
      check_eq("start_edge1_enable", 32'(async_enable), 32'(0));
      check_eq("start_edge1_starting", 32'(child_starting), 32'(1));
      check_eq("start_parent_request", 32'(parent_request), 32'(1));
      tick();
      check_eq("start_edge2_enable", 32'(async_enable), 32'(1));
      k = 0;
      while (!async_enable_ack && k < 20) begin
         tick();
         k++;
      end
      check_eq("en_ack_seen", 32'(async_enable_ack), 32'(1));
      k = 0;
      while (child_ready != 2'b01 && k < 20) begin
         tick();
         k++;
      end
      check_eq("run_latency", 32'(k), 32'(SYNC_STAGES + 1));
      check_eq("run_child_ready", 32'(child_ready), 32'(2'b01));
      model_running = 1'b1;

      run_cfg(8'd4, 8'd1, 8'd8);
      run_cfg(8'd3, 8'd5, 8'd5);

      for (int it = 0; it < 12; it++) begin
         stop_clock();
         en_dly = $urandom_range(1, 4);
         up_dly = $urandom_range(1, 4);
         if ($urandom_range(0, 2) != 0) start_clock(NUM_CHILD'($urandom_range(1, 3)));
         mode = $urandom_range(0, 3);
         cd = $urandom_range(1, 255);
         cn = $urandom_range(0, cd - 1);
         ci = $urandom_range(1, 255);
         case (mode)
            1: cd = 0;
            2: cn = $urandom_range(cd, 255);
            3: ci = 0;
            default: ;
         endcase
         run_cfg(8'(ci), 8'(cn), 8'(cd));
      end
      check_eq("no_fault_in_normal_ops", 32'(ack_fault), 32'(0));

      // Enable ack never arrives: fault after ACK_TIMEOUT+1 cycles in STARTING.
      stop_clock();
      en_auto = 1'b0;
      child_request = 2'b10;
      k = 0;
      while (!child_starting && k < 5) begin
         tick();
         k++;
      end
      k = 0;
      while (!ack_fault && k < 30) begin
         tick();
         k++;
      end
      check_eq("timeout_cycles", 32'(k), 32'(ACK_TIMEOUT + 1));
      parent_stopping = 1'b1;
      k = 0;
      while (dbg.state != ST_STOPPED && k < 30) begin
         tick();
         k++;
      end
      check_eq("timeout_stopped", 32'(dbg.state), 32'(ST_STOPPED));
      check_eq("fault_sticky", 32'(ack_fault), 32'(1));
      do_reset();
      check_eq("fault_cleared_by_reset", 32'(ack_fault), 32'(0));

      // Reset in the middle of an update handshake.
      en_auto = 1'b1;
      up_auto = 1'b0;
      repeat (16) tick();
      cfg_mfi = 8'd7;
      cfg_mfn = 8'd2;
      cfg_mfd = 8'd9;
      cfg_valid = 1'b1;
      k = 0;
      while (!async_update && k < 10) begin
         tick();
         k++;
      end
      check_eq("upd_strobe_seen", 32'(async_update), 32'(1));
      check_eq("upd_ratios_latched", 32'({mfi, mfn, mfd}), 32'({8'd7, 8'd2, 8'd9}));
      reset = 1'b1;
      cfg_valid = 1'b0;
      tick();
      check_eq("rst_mid_update_strobe", 32'(async_update), 32'(0));
      check_eq("rst_mid_update_ratios", 32'({mfi, mfn, mfd}), 32'({8'd2, 8'd3, 8'd5}));
      cr_seen = 0;
      if (cfg_ready) cr_seen++;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (cfg_ready) cr_seen++;
      end
      check_eq("rst_mid_update_no_cfg_ready", 32'(cr_seen), 32'(0));
      check_eq("rst_mid_update_state", 32'(dbg.state), 32'(ST_STOPPED));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
